// File: rtl/compare_pkg.sv
// Shared definitions for the compare/accumulate datapath: mode encodings,
// the reserved-mode range and the frame FSM state type.
package compare_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_EQ  = 3'd0;
  localparam logic [MODE_W-1:0] MODE_GT  = 3'd1;
  localparam logic [MODE_W-1:0] MODE_LT  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_MAX = 3'd3;
  localparam logic [MODE_W-1:0] MODE_MIN = 3'd4;

  // Encodings 5..7 are reserved: the beat still flows, but yields flag 0 / val 0.
  localparam logic [MODE_W-1:0] MODE_RSV_FIRST = 3'd5;
  localparam logic [MODE_W-1:0] MODE_RSV_LAST  = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  // True for encodings that carry no compare operation.
  function automatic logic mode_reserved(input logic [MODE_W-1:0] m);
    return (m >= MODE_RSV_FIRST) && (m <= MODE_RSV_LAST);
  endfunction

  // True for modes whose running value tracks an extreme (max/min).
  function automatic logic mode_extreme(input logic [MODE_W-1:0] m);
    return (m == MODE_MAX) || (m == MODE_MIN);
  endfunction

endpackage

// File: rtl/cmp_sel.sv
// Combinational comparator/selector: produces the per-beat flag and selected
// value for one mode. Also reused by the top to fold a beat into run_val.
module cmp_sel
  import compare_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0]  x,
  input  logic [WIDTH-1:0]  y,
  input  logic [MODE_W-1:0] mode,
  output logic              flag,
  output logic [WIDTH-1:0]  val
);

  logic is_eq;
  logic is_gt;
  logic is_lt;

  assign is_eq = (x == y);

  if (SIGNED != 0) begin : g_signed
    assign is_gt = ($signed(x) > $signed(y));
    assign is_lt = ($signed(x) < $signed(y));
  end else begin : g_unsigned
    assign is_gt = (x > y);
    assign is_lt = (x < y);
  end

  // Mode decode; a tie in MAX/MIN selects y with flag low.
  always_comb begin
    flag = 1'b0;
    val  = '0;
    case (mode)
      MODE_EQ: begin
        flag = is_eq;
        val  = x;
      end
      MODE_GT: begin
        flag = is_gt;
        val  = x;
      end
      MODE_LT: begin
        flag = is_lt;
        val  = x;
      end
      MODE_MAX: begin
        flag = is_gt;
        val  = is_gt ? x : y;
      end
      MODE_MIN: begin
        flag = is_lt;
        val  = is_lt ? x : y;
      end
      default: begin
        flag = 1'b0;
        val  = '0;
      end
    endcase
  end

endmodule

// File: rtl/compare_accum.sv
// Streaming compare/accumulate block. Each accepted beat is compared in the
// selected mode and presented one cycle later through a single result
// register; beats framed by first/last also fold into run_val/run_cnt, with a
// one-cycle done pulse when a frame closes.
module compare_accum
  import compare_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int CNT_W  = 8,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              in_ready,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  x,
  input  logic [WIDTH-1:0]  y,
  input  logic              first,
  input  logic              last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_flag,
  output logic [WIDTH-1:0]  out_val,
  output logic [WIDTH-1:0]  run_val,
  output logic [CNT_W-1:0]  run_cnt,
  output logic              done
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state;
  logic [MODE_W-1:0] mode_q;
  logic [MODE_W-1:0] eff_mode;
  logic              accept;
  logic              beat_flag;
  logic [WIDTH-1:0]  beat_val;
  logic              upd_flag;
  logic [WIDTH-1:0]  upd_val;
  logic              frame_open;
  logic              frame_end;

  // The result register can take a new beat whenever it is empty or draining.
  assign in_ready = !out_valid || out_ready;
  assign accept   = en && in_ready;

  assign frame_open = (state == ST_ACC);

  // A frame keeps the mode it started with; a first beat always re-reads it.
  assign eff_mode = (first || !frame_open) ? mode : mode_q;

  // Only a last that closes a real frame (open, or opened by this beat) ends it.
  assign frame_end = last && (first || frame_open);

  cmp_sel #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_beat (
    .x    (x),
    .y    (y),
    .mode (eff_mode),
    .flag (beat_flag),
    .val  (beat_val)
  );

  // Folding a beat into the running extreme: with the running value on y, a
  // high flag means the new beat wins; on a tie the running value is kept.
  cmp_sel #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_fold (
    .x    (beat_val),
    .y    (run_val),
    .mode (eff_mode),
    .flag (upd_flag),
    .val  (upd_val)
  );

  // Result register: load on acceptance, drop once downstream takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_flag  <= 1'b0;
      out_val   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_flag  <= beat_flag;
      out_val   <= beat_val;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Frame FSM with its accumulators and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      mode_q  <= MODE_EQ;
      run_val <= '0;
      run_cnt <= '0;
      done    <= 1'b0;
    end else begin
      done <= accept && frame_end;
      if (accept) begin
        if (first) begin
          // A first always restarts: any open frame is silently dropped.
          mode_q  <= mode;
          run_val <= beat_val;
          run_cnt <= CNT_W'(beat_flag);
          state   <= last ? ST_IDLE : ST_ACC;
        end else if (frame_open) begin
          if (beat_flag && (run_cnt != CNT_MAX)) begin
            run_cnt <= run_cnt + CNT_ONE;
          end
          if (mode_extreme(eff_mode)) begin
            if (upd_flag) begin
              run_val <= upd_val;
            end
          end else if (!mode_reserved(eff_mode)) begin
            if (beat_flag) begin
              run_val <= x;
            end
          end
          if (last) begin
            state <= ST_IDLE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_compare_accum.sv
// Bench for compare_accum: two instances share one stimulus stream
// (dut0 unsigned with a 2-bit counter, dut1 signed with an 8-bit counter).
// A frame-level reference model predicts every output each cycle; directed
// sequences pin the model with literal expectations.
module tb_compare_accum;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       first = 1'b0;
  logic       last = 1'b0;
  logic       out_ready = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [3:0] x = 4'd0;
  logic [3:0] y = 4'd0;

  logic       ir0, ov0, of0, dn0;
  logic [3:0] oval0, rv0;
  logic [1:0] rc0;
  logic       ir1, ov1, of1, dn1;
  logic [3:0] oval1, rv1;
  logic [7:0] rc1;

  int checks = 0;
  int failures = 0;
  int dn_cnt0 = 0;

  // reference model state
  int e_valid;
  int e_flag[2];
  int e_val[2];
  int e_done[2];
  int m_open[2];
  int m_mode[2];
  int m_rv[2];
  int m_rc[2];

  always #5 clk = ~clk;

  compare_accum #(.WIDTH(4), .CNT_W(2), .SIGNED(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_ready(ir0), .mode(mode),
    .x(x), .y(y), .first(first), .last(last), .out_valid(ov0),
    .out_ready(out_ready), .out_flag(of0), .out_val(oval0),
    .run_val(rv0), .run_cnt(rc0), .done(dn0)
  );

  compare_accum #(.WIDTH(4), .CNT_W(8), .SIGNED(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_ready(ir1), .mode(mode),
    .x(x), .y(y), .first(first), .last(last), .out_valid(ov1),
    .out_ready(out_ready), .out_flag(of1), .out_val(oval1),
    .run_val(rv1), .run_cnt(rc1), .done(dn1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // numeric value of a 4-bit code under the instance's signedness
  function automatic int num(input int v, input int sgn);
    return (sgn != 0 && v >= 8) ? v - 16 : v;
  endfunction

  function automatic int cnt_max(input int d);
    return (d == 0) ? 3 : 255;
  endfunction

  task automatic model_beat(input int md, input int sgn, input int xx, input int yy,
                            output int f, output int v);
    int a, b;
    a = num(xx, sgn);
    b = num(yy, sgn);
    f = 0;
    v = 0;
    case (md)
      0: begin f = (a == b) ? 1 : 0; v = xx; end
      1: begin f = (a > b) ? 1 : 0;  v = xx; end
      2: begin f = (a < b) ? 1 : 0;  v = xx; end
      3: begin f = (a > b) ? 1 : 0;  v = (a > b) ? xx : yy; end
      4: begin f = (a < b) ? 1 : 0;  v = (a < b) ? xx : yy; end
      default: begin f = 0; v = 0; end
    endcase
  endtask

  task automatic model_reset();
    e_valid = 0;
    for (int d = 0; d < 2; d++) begin
      e_flag[d] = 0; e_val[d] = 0; e_done[d] = 0;
      m_open[d] = 0; m_mode[d] = 0; m_rv[d] = 0; m_rc[d] = 0;
    end
  endtask

  // advance the model by one clock edge using the inputs now being driven
  task automatic model_step();
    int f, v, em;
    if (en && (e_valid == 0 || out_ready)) begin
      for (int d = 0; d < 2; d++) begin
        em = (first || m_open[d] == 0) ? int'(mode) : m_mode[d];
        model_beat(em, d, int'(x), int'(y), f, v);
        e_flag[d] = f;
        e_val[d]  = v;
        e_done[d] = (last && (first || m_open[d] != 0)) ? 1 : 0;
        if (first) begin
          m_rv[d]   = v;
          m_rc[d]   = f;
          m_mode[d] = int'(mode);
          m_open[d] = last ? 0 : 1;
        end else if (m_open[d] != 0) begin
          if (f != 0 && m_rc[d] < cnt_max(d)) m_rc[d]++;
          if (em == 3 && num(v, d) > num(m_rv[d], d)) m_rv[d] = v;
          if (em == 4 && num(v, d) < num(m_rv[d], d)) m_rv[d] = v;
          if (em <= 2 && f != 0) m_rv[d] = int'(x);
          if (last) m_open[d] = 0;
        end
      end
      e_valid = 1;
    end else begin
      if (out_ready) e_valid = 0;
      e_done[0] = 0;
      e_done[1] = 0;
    end
  endtask

  // per-cycle comparison against the model, just after each rising edge
  always @(posedge clk) begin
    #1;
    chk("ov0", ov0, e_valid);
    chk("ov1", ov1, e_valid);
    chk("ir0", ir0, (e_valid == 0 || out_ready) ? 1 : 0);
    chk("ir1", ir1, (e_valid == 0 || out_ready) ? 1 : 0);
    if (e_valid != 0) begin
      chk("of0", of0, e_flag[0]);
      chk("of1", of1, e_flag[1]);
      chk("oval0", oval0, e_val[0]);
      chk("oval1", oval1, e_val[1]);
    end
    chk("rv0", rv0, m_rv[0]);
    chk("rv1", rv1, m_rv[1]);
    chk("rc0", rc0, m_rc[0]);
    chk("rc1", rc1, m_rc[1]);
    chk("dn0", dn0, e_done[0]);
    chk("dn1", dn1, e_done[1]);
  end

  task automatic cycle(input bit e, input bit f, input bit l, input int md,
                       input int xx, input int yy, input bit ordy);
    @(negedge clk);
    en = e; first = f; last = l; mode = md[2:0];
    x = xx[3:0]; y = yy[3:0]; out_ready = ordy;
    if (rst_n) model_step();
    @(posedge clk);
    #2;
    dn_cnt0 += int'(dn0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en = 1'b0; first = 1'b0; last = 1'b0;
    model_reset();
    #2;
    chk("rst_ov", ov0, 0);
    chk("rst_of", of0, 0);
    chk("rst_oval", oval0, 0);
    chk("rst_rv", rv0, 0);
    chk("rst_rc", rc0, 0);
    chk("rst_dn", dn0, 0);
    chk("rst_ir", ir0, 1);
    chk("rst_rv1", rv1, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    out_ready = 1'b1;
    do_reset();

    // MAX frame (3,5),(9,2),(7,7)
    cycle(1, 1, 0, 3, 3, 5, 1);
    chk("max_val1", oval0, 5); chk("max_flag1", of0, 0); chk("max_dn1", dn0, 0);
    cycle(1, 0, 0, 3, 9, 2, 1);
    chk("max_val2", oval0, 9); chk("max_flag2", of0, 1); chk("max_dn2", dn0, 0);
    cycle(1, 0, 1, 3, 7, 7, 1);
    chk("max_val3", oval0, 7); chk("max_flag3", of0, 0); chk("max_dn3", dn0, 1);
    chk("max_rv", rv0, 9); chk("max_rc", rc0, 1);

    // signedness of GT
    cycle(1, 0, 0, 1, 15, 1, 1);
    chk("gt_unsigned", of0, 1); chk("gt_signed", of1, 0);

    // counter saturation
    dn_cnt0 = 0;
    cycle(1, 1, 0, 0, 2, 2, 1);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 2, 2, 1);
    cycle(1, 0, 1, 0, 2, 2, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);
    chk("sat_rc0", rc0, 3); chk("sat_rc1", rc1, 6); chk("sat_done_cnt", dn_cnt0, 1);

    // backpressure
    cycle(1, 0, 0, 0, 6, 6, 0);
    chk("bp_ov", ov0, 1); chk("bp_val", oval0, 6); chk("bp_ir", ir0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 0, 10, 3, 0);
      chk("bp_hold_val", oval0, 6); chk("bp_hold_flag", of0, 1); chk("bp_hold_ir", ir0, 0);
    end
    cycle(1, 0, 0, 0, 10, 3, 1);
    chk("bp_next_val", oval0, 10); chk("bp_next_flag", of0, 0); chk("bp_next_ov", ov0, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);
    chk("bp_drained", ov0, 0);

    // restart, one-beat frame, abort by reset
    cycle(1, 1, 0, 1, 5, 1, 1);
    cycle(1, 0, 0, 1, 7, 2, 1);
    chk("rs_rv", rv0, 7); chk("rs_rc", rc0, 2);
    cycle(1, 1, 0, 1, 8, 3, 1);
    chk("restart_dn", dn0, 0); chk("restart_rv", rv0, 8); chk("restart_rc", rc0, 1);
    cycle(1, 1, 1, 3, 4, 9, 1);
    chk("one_dn", dn0, 1); chk("one_val", oval0, 9); chk("one_flag", of0, 0);
    chk("one_rv", rv0, 9); chk("one_rc", rc0, 0);
    cycle(1, 1, 0, 1, 6, 2, 1);
    chk("open_dn", dn0, 0);
    cycle(1, 0, 0, 1, 7, 1, 1);
    do_reset();
    cycle(1, 0, 1, 1, 9, 1, 1);
    chk("post_rst_dn", dn0, 0); chk("post_rst_rv", rv0, 0);
    chk("post_rst_flag", of0, 1); chk("post_rst_val", oval0, 9);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 6) == 0),
              ($urandom_range(0, 6) == 0), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              ($urandom_range(0, 9) < 7));
      end
    end
    cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/compare_accum.md
COMPARE_ACCUM -- requirements
Module: compare_accum

Interface
REQ-001 Parameter WIDTH, default 4: operand width in bits, legal range 2..32.
REQ-002 Parameter CNT_W, default 8: width of the frame match counter.
REQ-003 Parameter SIGNED, default 0: 1 means two's-complement compare, 0 means unsigned.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 en  in  1  input beat valid.
REQ-007 in_ready  out  1  beat accepted when en && in_ready.
REQ-008 mode  in  3  0 EQ, 1 GT, 2 LT, 3 MAX, 4 MIN, 5..7 reserved.
REQ-009 x, y  in  WIDTH  operands.
REQ-010 first, last  in  1  frame delimiters, qualified by acceptance.
REQ-011 out_valid  out  1  result beat valid.
REQ-012 out_ready  in  1  downstream accepts the result when out_valid && out_ready.
REQ-013 out_flag  out  1  per-beat compare result.
REQ-014 out_val  out  WIDTH  per-beat selected value.
REQ-015 run_val  out  WIDTH  frame accumulator value.
REQ-016 run_cnt  out  CNT_W  frame match count.
REQ-017 done  out  1  one-cycle pulse at frame end.

Function
REQ-018 in_ready SHALL equal !out_valid || out_ready, giving a single result register with full throughput.
REQ-019 Latency SHALL be 1 cycle: an accepted beat appears on out_valid/out_flag/out_val on the next edge; the result is held unchanged while out_valid && !out_ready.
REQ-020 Effective mode: in IDLE, the live mode input; in ACC, the mode latched at frame start. A beat carrying first always uses the live mode.
REQ-021 EQ: flag = (x==y), val = x. GT: flag = (x>y), val = x. LT: flag = (x<y), val = x.
REQ-022 MAX: flag = (x>y), val = flag ? x : y. MIN: flag = (x<y), val = flag ? x : y. On a tie, val = y and flag = 0.
REQ-023 Reserved modes: flag = 0, val = 0, and the beat is still accepted and counted as a beat.
REQ-024 Comparisons SHALL honour SIGNED. All values are WIDTH bits, with no extension visible at the outputs.
REQ-025 FSM states: IDLE and ACC.
  - IDLE --(accepted first && !last)--> ACC
  - ACC --(accepted last)--> IDLE
REQ-026 Accepted first beat: run_val is loaded with that beat's val and run_cnt with its flag. This applies in any state, so a first in ACC discards the open frame, restarts accumulation and raises no done.
REQ-027 Accepted non-first beat in ACC:
  - run_cnt increments when flag = 1 and saturates at all-ones.
  - run_val update in MAX mode: max(run_val, val).
  - run_val update in MIN mode: min(run_val, val).
  - run_val update in EQ/GT/LT modes: becomes x when flag = 1, otherwise held.
REQ-028 An accepted beat with last (in ACC, or with first) SHALL pulse done for exactly the cycle its result is first presented. run_val/run_cnt then hold final values until the next first.
REQ-029 first && last on one beat SHALL form a one-beat frame: accumulators loaded, done pulsed, state remains IDLE.
REQ-030 Beats in IDLE without first SHALL produce per-beat results only; the accumulators and done are unaffected. A last in IDLE without first is ignored for framing.
REQ-031 Beats not accepted (en low or in_ready low) SHALL change no state.

Reset
REQ-032 While rst_n is low, all outputs SHALL be 0 except in_ready, which SHALL be 1; the state SHALL be IDLE and the latched mode EQ.
REQ-033 Reset asserted mid-frame SHALL abandon the frame with no done; after release the next frame requires first.

Structure
REQ-034 Mode encodings (EQ..MIN), the FSM state typedef and the reserved-mode range SHALL live in shared package compare_pkg.
REQ-035 The per-beat comparator/selector SHALL be one combinational sub-module cmp_sel (parameters WIDTH, SIGNED; inputs x, y, mode; outputs flag, val), reused for the run_val MAX/MIN update.

Verification
REQ-036 WIDTH=4, unsigned, MAX mode, frame x/y = (3,5),(9,2),(7,7) with last on the third beat -> out_val 5, 9, 7; out_flag 0, 1, 0; done on the third result; run_val 9; run_cnt 1.
REQ-037 SIGNED=1, WIDTH=4, GT mode, x=4'hF (-1), y=4'h1 -> out_flag 0; the same beat with SIGNED=0 -> out_flag 1.
REQ-038 CNT_W=2, EQ mode, 5 equal beats then last -> run_cnt saturates at 3; done occurs once.
REQ-039 Hold out_ready low for 3 cycles with en high -> in_ready low, result held stable, no beat lost or duplicated after release.
REQ-040 first mid-frame, then first&&last one-beat frame, then rst_n pulsed mid-frame -> no done for the restarted or aborted frames; done for the one-beat frame; all outputs 0 and in_ready 1 during reset.
